fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// Instruction-fetch stage sitting directly upstream of the decoder. Holds the fetch PC,
// issues word reads to instruction memory (one outstanding request max), and presents
// {instruction, pc, instr_valid} to decode. Handles downstream stall and jump/branch
// redirects, discarding any in-flight fetch made stale by a redirect.
// PARAMETERS
// RESET_PC  32'h8002_0000  fetch address loaded on reset
// PORTS
// clock            in   1   single clock; all state updates on rising edge
// reset            in   1   asynchronous, active-high
// stall            in   1   decode cannot accept; output register must hold
// redirect_valid   in   1   one-cycle pulse: resteer fetch (jump/branch taken)
// redirect_target  in   32  new fetch address
// imem_req         out  1   read request this cycle (memory always accepts)
// imem_addr        out  32  request address (= fetch_pc)
// imem_rvalid      in   1   read data valid, >=1 cycle after imem_req
// imem_rdata       in   32  instruction word
// instruction      out  32  registered instruction to decoder
// pc               out  32  registered address of `instruction`
// instr_valid      out  1   instruction/pc valid
// addr_error       out  1   registered one-cycle pulse: misaligned redirect target
// BEHAVIOUR
// - Reset (async): fetch_pc=RESET_PC, state=ISSUE, instruction=0 (NOP), pc=0,
//   instr_valid=0, addr_error=0. imem_req=0 while reset asserted.
// - States: ISSUE (no request outstanding), WAIT (request outstanding, result wanted),
//   DISCARD (request outstanding, result to be dropped).
// - slot_free = !instr_valid || !stall (output empty or consumed this cycle).
// - imem_req = (state==ISSUE) && slot_free && !redirect_valid; imem_addr = fetch_pc.
//   On issue: fetch_pc <= fetch_pc+4 (mod 2^32), state->WAIT, issued addr latched as req_pc.
// - Consume: instr_valid && !stall at an edge -> instr_valid<=0 unless reloaded same edge.
// - WAIT & imem_rvalid & !redirect_valid: instruction<=imem_rdata, pc<=req_pc,
//   instr_valid<=1, state->ISSUE. Slot is guaranteed free (issue required slot_free).
// - Best throughput: one instruction per 2 cycles with 1-cycle memory.
// - redirect_valid (priority over stall and rvalid):
//   fetch_pc<=redirect_target & ~32'h3; instr_valid<=0 (flush);
//   addr_error<=|redirect_target[1:0] for one cycle;
//   ISSUE->ISSUE (no request this cycle); WAIT->DISCARD, but if imem_rvalid same cycle
//   data is dropped and state->ISSUE; DISCARD->DISCARD (or ISSUE if rvalid same cycle).
// - DISCARD & imem_rvalid: data dropped, outputs untouched, state->ISSUE.
// - imem_rvalid in ISSUE (no outstanding request, e.g. after reset mid-WAIT): ignored.
// - Stall holds instruction/pc/instr_valid stable; no new request while slot occupied.
// - Delay-slot contract: decode raises redirect only after the delay-slot instruction has
//   been consumed; fetch flushes everything younger without exception.
// TESTING
// T1 reset release: imem_req=1, imem_addr=0x80020000; rvalid next cycle with 0x24020005
//    -> instruction=0x24020005, pc=0x80020000, instr_valid=1; next req addr 0x80020004.
// T2 stall=1 for 3 cycles with instr_valid=1 -> outputs constant, imem_req=0;
//    stall drops -> imem_req=1 same cycle to next sequential addr.
// T3 redirect to 0x80020100 while WAIT on 0x80020008, rvalid 2 cycles later with
//    0xDEADBEEF -> dropped, instr_valid stays 0, next req addr 0x80020100.
// T4 redirect and imem_rvalid same cycle -> data dropped, req 0x80020100 next cycle.
// T5 redirect target 0x80020102 -> addr_error=1 for exactly one cycle; req 0x80020100.
// T6 redirect to 0xFFFFFFFC, fetch completes -> pc=0xFFFFFFFC, next req 0x00000000;
//    reset asserted mid-WAIT then stray rvalid -> ignored, first req 0x80020000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one instruction-memory read
// outstanding, and hands {instruction, pc} to decode, resteering on jumps/branches.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8002_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        instr_valid,
   output logic        addr_error,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ISSUE   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic        slot_free;

   // Handshakes: memory accepts a read in any cycle imem_req is high and later returns
   // exactly one imem_rvalid for it; decode takes the output word at an edge where
   // instr_valid is high and stall is low.
   assign slot_free = !instr_valid || !stall;
   assign imem_req  = !reset && (state == ISSUE) && slot_free && !redirect_valid;
   assign imem_addr = fetch_pc;
   assign dbg_state = state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ISSUE;
         fetch_pc    <= RESET_PC;
         req_pc      <= '0;
         instruction <= '0;
         pc          <= '0;
         instr_valid <= 1'b0;
         addr_error  <= 1'b0;
      end else begin
         addr_error <= 1'b0;
         if (instr_valid && !stall)
            instr_valid <= 1'b0;

         if (redirect_valid) begin
            // A redirect flushes everything younger; any in-flight read becomes stale.
            fetch_pc    <= redirect_target & ~32'h3;
            instr_valid <= 1'b0;
            addr_error  <= |redirect_target[1:0];
            case (state)
               ISSUE:   state <= ISSUE;
               WAIT:    state <= imem_rvalid ? ISSUE : DISCARD;
               DISCARD: state <= imem_rvalid ? ISSUE : DISCARD;
               default: state <= ISSUE;
            endcase
         end else begin
            case (state)
               ISSUE: begin
                  if (imem_req) begin
                     fetch_pc <= fetch_pc + 32'd4;
                     req_pc   <= fetch_pc;
                     state    <= WAIT;
                  end
               end
               WAIT: begin
                  if (imem_rvalid) begin
                     instruction <= imem_rdata;
                     pc          <= req_pc;
                     instr_valid <= 1'b1;
                     state       <= ISSUE;
                  end
               end
               DISCARD: begin
                  if (imem_rvalid)
                     state <= ISSUE;
               end
               default: state <= ISSUE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed redirect/stall/reset scenarios plus a randomized
// sequential-fetch run, with a scoreboard of expected {pc, instruction} pairs.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        instr_valid;
   logic        addr_error;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_bad    = 0;
   logic [63:0] exp_q[$];
   logic        prev_valid = 1'b0;

   fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instruction     (instruction),
      .pc              (pc),
      .instr_valid     (instr_valid),
      .addr_error      (addr_error),
      .dbg_state       (dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clock);
      #1;
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic mem_resp(input logic [31:0] data, input logic [31:0] addr, input bit keep);
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      if (keep) exp_q.push_back({addr, data});
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid  = 1'b1;
      redirect_target = target;
   endtask

   // scoreboard: every new output word is compared against the oldest expectation
   always @(negedge clock) begin
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_pc", pc, 32'hxxxx_xxxx);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               check("sb_pc", pc, e[63:32]);
               check("sb_instr", instruction, e[31:0]);
            end
         end
         prev_valid = instr_valid;
      end
   end

   initial begin
      logic [31:0] held_instr;
      logic [31:0] held_pc;
      logic [31:0] exp_addr;
      logic [31:0] data;
      int          budget;
      int          lat;

      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      repeat (2) @(posedge clock);
      #2;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instruction, 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_aerr", {31'd0, addr_error}, 32'd0);

      // T1: first fetch after reset
      @(posedge clock); #1;
      reset = 1'b0;
      settle();
      check("t1_req", {31'd0, imem_req}, 32'd1);
      check("t1_addr", imem_addr, 32'h8002_0000);
      step();
      mem_resp(32'h2402_0005, 32'h8002_0000, 1'b1);
      settle();
      check("t1_wait_noreq", {31'd0, imem_req}, 32'd0);
      step();
      check("t1_valid", {31'd0, instr_valid}, 32'd1);
      check("t1_instr", instruction, 32'h2402_0005);

      // T2: stall holds the output register and blocks requests
      stall = 1'b1;
      held_instr = instruction;
      held_pc    = pc;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("t2_noreq", {31'd0, imem_req}, 32'd0);
         check("t2_instr_hold", instruction, held_instr);
         check("t2_pc_hold", pc, held_pc);
         check("t2_valid_hold", {31'd0, instr_valid}, 32'd1);
         step();
      end
      stall = 1'b0;
      settle();
      check("t2_req", {31'd0, imem_req}, 32'd1);
      check("t2_addr", imem_addr, 32'h8002_0004);
      step();
      check("t2_consumed", {31'd0, instr_valid}, 32'd0);
      mem_resp(32'h0000_0013, 32'h8002_0004, 1'b1);
      step();
      settle();
      check("t2_next_addr", imem_addr, 32'h8002_0008);
      step();

      // T3: redirect while waiting; late data is dropped
      redirect(32'h8002_0100);
      settle();
      check("t3_noreq", {31'd0, imem_req}, 32'd0);
      step();
      check("t3_state", {30'd0, dbg_state}, 32'd2);
      check("t3_flush", {31'd0, instr_valid}, 32'd0);
      step();
      mem_resp(32'hDEAD_BEEF, 32'h0, 1'b0);
      settle();
      check("t3_discard_noreq", {31'd0, imem_req}, 32'd0);
      step();
      settle();
      check("t3_dropped", {31'd0, instr_valid}, 32'd0);
      check("t3_req", {31'd0, imem_req}, 32'd1);
      check("t3_addr", imem_addr, 32'h8002_0100);
      step();

      // T4: redirect and rvalid in the same cycle
      redirect(32'h8002_0100);
      mem_resp(32'hBADC_0DE0, 32'h0, 1'b0);
      step();
      settle();
      check("t4_dropped", {31'd0, instr_valid}, 32'd0);
      check("t4_req", {31'd0, imem_req}, 32'd1);
      check("t4_addr", imem_addr, 32'h8002_0100);
      step();
      mem_resp(32'h1111_1111, 32'h8002_0100, 1'b1);
      step();

      // T5: misaligned redirect under stall flushes and pulses addr_error once
      stall = 1'b1;
      redirect(32'h8002_0102);
      settle();
      check("t5_noreq", {31'd0, imem_req}, 32'd0);
      step();
      check("t5_aerr", {31'd0, addr_error}, 32'd1);
      check("t5_flush", {31'd0, instr_valid}, 32'd0);
      stall = 1'b0;
      settle();
      check("t5_addr", imem_addr, 32'h8002_0100);
      check("t5_req", {31'd0, imem_req}, 32'd1);
      step();
      check("t5_aerr_clear", {31'd0, addr_error}, 32'd0);
      mem_resp(32'h2222_2222, 32'h8002_0100, 1'b1);
      step();

      // T6: wrap at top of address space, then reset mid-wait with a stray rvalid
      redirect(32'hFFFF_FFFC);
      step();
      check("t6_aerr", {31'd0, addr_error}, 32'd0);
      settle();
      check("t6_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      mem_resp(32'h3333_3333, 32'hFFFF_FFFC, 1'b1);
      step();
      settle();
      check("t6_wrap_addr", imem_addr, 32'h0000_0000);
      step();
      reset = 1'b1;
      settle();
      check("t6_rst_noreq", {31'd0, imem_req}, 32'd0);
      check("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
      step();
      reset = 1'b0;
      mem_resp(32'h4444_4444, 32'h0, 1'b0);
      settle();
      check("t6_req", {31'd0, imem_req}, 32'd1);
      check("t6_addr_reset", imem_addr, 32'h8002_0000);
      step();
      check("t6_stray_ignored", {31'd0, instr_valid}, 32'd0);
      mem_resp(32'h5555_5555, 32'h8002_0000, 1'b1);
      step();

      // randomized sequential fetch with variable latency and stall
      exp_addr = 32'h8002_0004;
      for (int n = 0; n < 30; n++) begin
         budget = 0;
         while (1) begin
            stall = ($urandom_range(0, 3) == 0);
            settle();
            if (imem_req) break;
            step();
            budget++;
            if (budget > 40) begin
               check("rnd_req_timeout", 32'd0, 32'd1);
               break;
            end
         end
         if (budget > 40) break;
         check("rnd_addr", imem_addr, exp_addr);
         step();
         lat = $urandom_range(0, 2);
         for (int k = 0; k < lat; k++) begin
            stall = $urandom_range(0, 1);
            step();
         end
         data = $urandom;
         mem_resp(data, exp_addr, 1'b1);
         exp_addr = exp_addr + 32'd4;
         step();
      end
      stall = 1'b0;
      repeat (2) step();
      check("sb_drain", exp_q.size(), 32'd0);

      // final report
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
